// File: rtl/axi4lite_req_arbiter.sv
// axi4lite_req_arbiter: two-requester round-robin front end for a single AXI4-Lite master command port.
// Optional WAIT-state timeout compiled in with `define AXI_ARB_TIMEOUT_EN.
`default_nettype none

module axi4lite_req_arbiter #(
  parameter int ADDR_WIDTH     = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              ack,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    err,
  output logic                    busy,
  output logic                    grant_id,
  output logic                    m_start_write,
  output logic                    m_start_read,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  input  logic                    m_done,
  input  logic [DATA_WIDTH-1:0]   m_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t state_q;
  logic   last_grant_q;
  logic   we_q;
  logic   win_d;

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  always_comb begin
    win_d = req[1] & (~req[0] | ~last_grant_q);
  end

`ifdef AXI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      last_grant_q  <= 1'b1;
      we_q          <= 1'b0;
      ack           <= 2'b00;
      rdata         <= '0;
      busy          <= 1'b0;
      grant_id      <= 1'b0;
      m_start_write <= 1'b0;
      m_start_read  <= 1'b0;
      m_addr        <= '0;
      m_wdata       <= '0;
`ifdef AXI_ARB_TIMEOUT_EN
      err           <= 1'b0;
      tmo_q         <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req != 2'b00) begin
            state_q       <= S_ISSUE;
            busy          <= 1'b1;
            grant_id      <= win_d;
            we_q          <= req_we[win_d];
            m_start_write <= req_we[win_d];
            m_start_read  <= ~req_we[win_d];
            m_addr        <= win_d ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                   : req_addr[ADDR_WIDTH-1:0];
            m_wdata       <= win_d ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                   : req_wdata[DATA_WIDTH-1:0];
          end
        end
        S_ISSUE: begin
          m_start_write <= 1'b0;
          m_start_read  <= 1'b0;
          state_q       <= S_WAIT;
`ifdef AXI_ARB_TIMEOUT_EN
          tmo_q         <= '0;
`endif
        end
        S_WAIT: begin
          if (m_done) begin
            if (!we_q) begin
              rdata <= m_rdata;
            end
            ack     <= grant_id ? 2'b10 : 2'b01;
            state_q <= S_ACK;
`ifdef AXI_ARB_TIMEOUT_EN
            err     <= 1'b0;
          end else if (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // Give up: complete to the requester with an error, data untouched.
            ack     <= grant_id ? 2'b10 : 2'b01;
            err     <= 1'b1;
            state_q <= S_ACK;
          end else begin
            tmo_q   <= tmo_q + 1'b1;
`endif
          end
        end
        S_ACK: begin
          ack          <= 2'b00;
          busy         <= 1'b0;
          last_grant_q <= grant_id;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/axi4lite_req_arbiter.md
# axi4lite_req_arbiter

Round-robin scheduler that shares the single AXI4-Lite master command port (start_write/start_read, address, data, done) between two independent requesters. Each requester sees a simple request/acknowledge interface. The arbiter latches one request and issues it to the master as a one-cycle start pulse. It waits for done, returns read data and acknowledge, then re-arbitrates. Only one transaction is outstanding at any time; the block sits between user logic and the AXI4-Lite master in the top level.

## Interface
- ADDR_WIDTH, 2, address width of each request and of the master port
- DATA_WIDTH, 8, data width
- TIMEOUT_CYCLES, 15, maximum WAIT-state cycles; used only when the timeout feature is compiled in
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  2  level request per requester i; held until ack[i]
- req_we  in  2  1 = write, 0 = read, per requester
- req_addr  in  2*ADDR_WIDTH  requester i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  2*DATA_WIDTH  requester i write data at [i*DATA_WIDTH +: DATA_WIDTH]
- ack  out  2  one-cycle completion pulse to the granted requester
- rdata  out  DATA_WIDTH  read data; valid with ack; held until the next read completes
- err  out  1  timeout flag; valid with ack; constant 0 when the feature is compiled out
- busy  out  1  high whenever state is not IDLE
- grant_id  out  1  requester owning the current or most recent transaction
- m_start_write  out  1  one-cycle write start to the master
- m_start_read  out  1  one-cycle read start to the master
- m_addr  out  ADDR_WIDTH  latched address; stable from ISSUE through WAIT
- m_wdata  out  DATA_WIDTH  latched write data; stable from ISSUE through WAIT
- m_done  in  1  completion pulse from the master
- m_rdata  in  DATA_WIDTH  master read data; valid with m_done

## Operation
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If any req bit is set, grant and go to ISSUE.
  - When only one requester is asking, it wins.
  - When both are asking, the winner is the requester other than last_grant.
  - On grant, latch we, addr and wdata of the winner, and set grant_id.
- ISSUE: assert m_start_write (if we) or m_start_read for exactly this cycle, then go to WAIT.
- WAIT:
  - m_done is sampled only in this state.
  - On m_done, capture m_rdata into rdata if the transaction is a read, then go to ACK.
  - rdata is unchanged on writes.
- ACK: ack[grant_id] = 1 for one cycle, last_grant <= grant_id, then go to IDLE.
- Inputs are ignored outside IDLE. A req that drops mid-transaction does not abort the transaction; ack still pulses.
- A req still high in the cycle after ack is a new request and is re-arbitrated normally.
- Reset values:
  - state = IDLE, last_grant = 1 (requester 0 wins the first tie).
  - Outputs ack, rdata, err, busy, grant_id, m_start_*, m_addr and m_wdata are all 0.
- Reset mid-operation: the in-flight transaction is dropped with no ack. Any m_done arriving afterwards in IDLE is ignored.

## Timing
- The edge that samples req in IDLE moves the FSM to ISSUE; m_start_* is high during the following cycle.
- The edge that samples m_done in WAIT moves the FSM to ACK; ack is high during the following cycle.
- Minimum req-to-ack latency: 3 cycles plus the master's start-to-done latency.
- The master must not assert m_done in the same cycle as m_start_*. A done in ISSUE is ignored.
- Back-to-back requests: at least one IDLE cycle separates ack from the next m_start_* (4-cycle issue period minimum).

## Configuration
- Macro: AXI_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without m_done.
  - If TIMEOUT_CYCLES WAIT cycles pass with no done, go to ACK with err = 1; rdata is unchanged.
  - err is 0 on normal completion.
  - A stray late m_done is not filtered; the integrator guarantees the master cannot complete after a timeout.
- Not defined: no counter, WAIT is unbounded, and err is tied 0.

## Test plan
- Write from requester 0, addr = 2, wdata = 0x04; master done 3 cycles after start → one m_start_write pulse with m_addr = 2 and m_wdata = 0x04; then ack[0] pulse with err = 0 and rdata unchanged.
- Read from requester 1, addr = 2; m_rdata = 0x04 with done → ack[1] pulse with rdata = 0x04 and grant_id = 1.
- Both req held high from reset, fixed 2-cycle master → grant order 0,1,0,1; exactly one ack per transaction.
- Requester 0 drops req during WAIT → transaction completes and ack[0] still pulses.
- rst asserted during WAIT → all outputs 0 immediately; a subsequent requester 1 read is served normally.
- With AXI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 15, m_done never asserted → ack with err = 1 after 15 WAIT cycles; busy returns to 0 one cycle later.
